// File: rtl/ins_mem_responder.sv
// Instruction memory responder: serves one-cycle fetch pulses from the control
// unit with a fixed-latency registered read, a one-deep pending request slot,
// a sticky overflow flag and a program-load write port.
module ins_mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] CntInit = 4'(RD_LAT - 1);
  // A one-cycle latency skips the wait phase entirely.
  localparam logic [1:0] StStart = (RD_LAT > 1) ? StWait : StResp;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] ins_q;
  logic              start;
  logic [ADDR_W-1:0] start_addr;

  logic [DATA_W-1:0] mem [Depth];

  // Next-state: accept, queue or drop requests and step the latency counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_addr_d  = cur_addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ovf_d       = ovf_q;
    start       = 1'b0;
    start_addr  = addr;

    case (state_q)
      StIdle: begin
        start = en_ram_in;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaching zero after this decrement enters the response cycle.
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
        if (en_ram_in) begin
          if (pend_q) begin
            ovf_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_addr_d = addr;
          end
        end
      end
      StResp: begin
        if (pend_q) begin
          // Queued request starts as if it arrived at this edge.
          start      = 1'b1;
          start_addr = pend_addr_q;
          pend_d     = 1'b0;
          if (en_ram_in) begin
            ovf_d = 1'b1;
          end
        end else if (en_ram_in) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start) begin
      cur_addr_d = start_addr;
      cnt_d      = CntInit;
      state_d    = StStart;
    end
  end

  // Control state and the registered read word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cur_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      ovf_q       <= 1'b0;
      ins_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      ovf_q       <= ovf_d;
      // Only reachable by entering RESP, so this is the edge that captures data.
      // Same-edge writes land after this read, so the old word is returned.
      if (state_d == StResp) begin
        ins_q <= mem[cur_addr_d];
      end
    end
  end

  // Program-load port; independent of reset and FSM state.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign ins        = ins_q;
  assign en_ram_out = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ins_mem_responder.sv
// Bench for ins_mem_responder: three instances with latencies 1, 2 and 3 share
// stimulus; directed scenarios check hand-derived timing, and a randomized run
// compares every output against a timestamp-based reference model.
module tb_ins_mem_responder;

  logic        clk;
  logic        rst;
  logic        en_ram_in;
  logic [7:0]  addr;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  logic [15:0] ins_w [3];
  logic        ero_w [3];
  logic        busy_w[3];
  logic        ovf_w [3];

  int errors = 0;
  int checks = 0;

  // Reference model: each in-flight request is described by the edge at which
  // its response cycle begins; index i models latency i+1.
  logic [15:0] mmem [256];
  int          edge_n = 0;
  bit          m_cur_v [3];
  int          m_resp_e[3];
  logic [7:0]  m_cur_a [3];
  bit          m_pend_v[3];
  logic [7:0]  m_pend_a[3];
  bit          m_ovf   [3];
  bit          m_ero   [3];
  bit          m_busy  [3];
  logic [15:0] m_ins   [3];

  ins_mem_responder #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ins(ins_w[0]), .en_ram_out(ero_w[0]),
    .busy(busy_w[0]), .ovf(ovf_w[0])
  );
  ins_mem_responder #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ins(ins_w[1]), .en_ram_out(ero_w[1]),
    .busy(busy_w[1]), .ovf(ovf_w[1])
  );
  ins_mem_responder #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ins(ins_w[2]), .en_ram_out(ero_w[2]),
    .busy(busy_w[2]), .ovf(ovf_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_start(input int i, input logic [7:0] a);
    m_cur_v[i]  = 1'b1;
    m_cur_a[i]  = a;
    m_resp_e[i] = edge_n + i;  // response begins latency-1 edges later
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_cur_v[i]  = 1'b0;
        m_pend_v[i] = 1'b0;
        m_ovf[i]    = 1'b0;
        m_ins[i]    = 16'h0;
      end else if (m_cur_v[i] && m_resp_e[i] == edge_n - 1) begin
        if (m_pend_v[i]) begin
          model_start(i, m_pend_a[i]);
          m_pend_v[i] = 1'b0;
          if (en_ram_in) m_ovf[i] = 1'b1;
        end else if (en_ram_in) begin
          model_start(i, addr);
        end else begin
          m_cur_v[i] = 1'b0;
        end
      end else if (m_cur_v[i]) begin
        if (en_ram_in) begin
          if (m_pend_v[i]) m_ovf[i] = 1'b1;
          else begin
            m_pend_v[i] = 1'b1;
            m_pend_a[i] = addr;
          end
        end
      end else if (en_ram_in) begin
        model_start(i, addr);
      end
      m_ero[i]  = rst && m_cur_v[i] && (m_resp_e[i] == edge_n);
      m_busy[i] = rst && m_cur_v[i];
      if (m_ero[i]) m_ins[i] = mmem[m_cur_a[i]];
    end
    if (ld_we) mmem[ld_addr] = ld_data;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle to negedge.
  task automatic cyc(input logic r, input logic q, input logic [7:0] a, input logic w,
                     input logic [7:0] la, input logic [15:0] ld);
    rst = r; en_ram_in = q; addr = a; ld_we = w; ld_addr = la; ld_data = ld;
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_preload();
    for (int a = 0; a < 256; a++) cyc(1'b0, 1'b0, 8'h0, 1'b1, 8'(a), 16'($urandom));
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 8'(k), 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
        checks += 4;
        if (ins_w[i] !== 16'h0) begin
          errors++; $display("FAIL reset_ins dut%0d got %h want 0000", i, ins_w[i]);
        end
        if (ero_w[i] !== 1'b0) begin
          errors++; $display("FAIL reset_ero dut%0d got %b want 0", i, ero_w[i]);
        end
        if (busy_w[i] !== 1'b0) begin
          errors++; $display("FAIL reset_busy dut%0d got %b want 0", i, busy_w[i]);
        end
        if (ovf_w[i] !== 1'b0) begin
          errors++; $display("FAIL reset_ovf dut%0d got %b want 0", i, ovf_w[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'h05, 16'hA123);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, k == 0, 8'h05, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (ero_w[i] !== (k == i)) begin
          errors++; $display("FAIL single_ero dut%0d k=%0d got %b want %b", i, k, ero_w[i], k == i);
        end
        if (busy_w[i] !== (k <= i)) begin
          errors++; $display("FAIL single_busy dut%0d k=%0d got %b want %b", i, k, busy_w[i], k <= i);
        end
        if (k == i) begin
          checks++;
          if (ins_w[i] !== 16'hA123) begin
            errors++; $display("FAIL single_ins dut%0d got %h want a123", i, ins_w[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d1, d2;
    d1 = 16'($urandom); d2 = ~d1;
    cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'h01, d1);
    cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'h02, d2);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, k < 2, (k == 0) ? 8'h01 : 8'h02, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
        int r1, r2;
        r1 = i; r2 = 2 * i + 1;
        checks++;
        if (ero_w[i] !== (k == r1 || k == r2)) begin
          errors++; $display("FAIL b2b_ero dut%0d k=%0d got %b want %b", i, k, ero_w[i],
                             k == r1 || k == r2);
        end
        if (k == r1 || k == r2) begin
          checks++;
          if (ins_w[i] !== ((k == r1) ? d1 : d2)) begin
            errors++; $display("FAIL b2b_ins dut%0d k=%0d got %h want %h", i, k, ins_w[i],
                               (k == r1) ? d1 : d2);
          end
        end
        if (k == 7) begin
          checks++;
          if (ovf_w[i] !== 1'b0) begin
            errors++; $display("FAIL b2b_ovf dut%0d got %b want 0", i, ovf_w[i]);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d [3];
    for (int j = 0; j < 3; j++) begin
      d[j] = 16'($urandom);
      cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'(8'h30 + j), d[j]);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, k < 3, 8'(8'h30 + k), 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
        bit exp_ero, exp_ovf;
        logic [15:0] exp_ins;
        exp_ins = 16'h0;
        case (i)
          0: begin
            exp_ero = (k < 3); exp_ovf = 1'b0; if (k < 3) exp_ins = d[k];
          end
          1: begin
            exp_ero = (k == 1 || k == 3); exp_ovf = (k >= 2);
            exp_ins = (k == 1) ? d[0] : d[1];
          end
          default: begin
            exp_ero = (k == 2 || k == 5); exp_ovf = (k >= 2);
            exp_ins = (k == 2) ? d[0] : d[1];
          end
        endcase
        checks += 2;
        if (ero_w[i] !== exp_ero) begin
          errors++; $display("FAIL ovf_ero dut%0d k=%0d got %b want %b", i, k, ero_w[i], exp_ero);
        end
        if (ovf_w[i] !== exp_ovf) begin
          errors++; $display("FAIL ovf_flag dut%0d k=%0d got %b want %b", i, k, ovf_w[i], exp_ovf);
        end
        if (exp_ero) begin
          checks++;
          if (ins_w[i] !== exp_ins) begin
            errors++; $display("FAIL ovf_ins dut%0d k=%0d got %h want %h", i, k, ins_w[i], exp_ins);
          end
        end
      end
    end
  endtask

  // Latency-2 instance: overwrite lands on the same edge that captures the read.
  task automatic test_collision();
    cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'h10, 16'h1111);
    cyc(1'b1, 1'b1, 8'h10, 1'b0, 8'h0, 16'h0);
    cyc(1'b1, 1'b0, 8'h0, 1'b1, 8'h10, 16'h2222);
    checks += 2;
    if (ero_w[1] !== 1'b1) begin
      errors++; $display("FAIL coll_ero got %b want 1", ero_w[1]);
    end
    if (ins_w[1] !== 16'h1111) begin
      errors++; $display("FAIL coll_old got %h want 1111", ins_w[1]);
    end
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 16'h0);
    cyc(1'b1, 1'b1, 8'h10, 1'b0, 8'h0, 16'h0);
    cyc(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 16'h0);
    checks += 2;
    if (ero_w[1] !== 1'b1) begin
      errors++; $display("FAIL coll_ero2 got %b want 1", ero_w[1]);
    end
    if (ins_w[1] !== 16'h2222) begin
      errors++; $display("FAIL coll_new got %h want 2222", ins_w[1]);
    end
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic test_reset_abort();
    cyc(1'b1, 1'b1, 8'h05, 1'b0, 8'h0, 16'h0);
    cyc(1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (ins_w[i] !== 16'h0) begin
        errors++; $display("FAIL abort_ins dut%0d got %h want 0000", i, ins_w[i]);
      end
      if (ero_w[i] !== 1'b0) begin
        errors++; $display("FAIL abort_ero dut%0d got %b want 0", i, ero_w[i]);
      end
      if (busy_w[i] !== 1'b0) begin
        errors++; $display("FAIL abort_busy dut%0d got %b want 0", i, busy_w[i]);
      end
      if (ovf_w[i] !== 1'b0) begin
        errors++; $display("FAIL abort_ovf dut%0d got %b want 0", i, ovf_w[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 16'h0);
      checks += 2;
      if (ero_w[2] !== 1'b0) begin
        errors++; $display("FAIL abort_noresp k=%0d got %b want 0", k, ero_w[2]);
      end
      if (busy_w[2] !== 1'b0) begin
        errors++; $display("FAIL abort_idle k=%0d got %b want 0", k, busy_w[2]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, k == 0, 8'h05, 1'b0, 8'h0, 16'h0);
      checks++;
      if (ero_w[2] !== (k == 2)) begin
        errors++; $display("FAIL abort_after_ero k=%0d got %b want %b", k, ero_w[2], k == 2);
      end
      if (k == 2) begin
        checks++;
        if (ins_w[2] !== 16'hA123) begin
          errors++; $display("FAIL abort_after_ins got %h want a123", ins_w[2]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), 8'($urandom),
          ($urandom_range(0, 3) == 0), 8'($urandom), 16'($urandom));
      for (int i = 0; i < 3; i++) begin
        checks += 4;
        if (ins_w[i] !== m_ins[i]) begin
          errors++; $display("FAIL rand_ins dut%0d n=%0d got %h want %h", i, n, ins_w[i], m_ins[i]);
        end
        if (ero_w[i] !== m_ero[i]) begin
          errors++; $display("FAIL rand_ero dut%0d n=%0d got %b want %b", i, n, ero_w[i], m_ero[i]);
        end
        if (busy_w[i] !== m_busy[i]) begin
          errors++; $display("FAIL rand_busy dut%0d n=%0d got %b want %b", i, n, busy_w[i],
                             m_busy[i]);
        end
        if (ovf_w[i] !== m_ovf[i]) begin
          errors++; $display("FAIL rand_ovf dut%0d n=%0d got %b want %b", i, n, ovf_w[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; en_ram_in = 1'b0; addr = 8'h0; ld_we = 1'b0; ld_addr = 8'h0; ld_data = 16'h0;
    for (int i = 0; i < 3; i++) begin
      m_cur_v[i] = 1'b0; m_pend_v[i] = 1'b0; m_ovf[i] = 1'b0; m_ins[i] = 16'h0;
      m_ero[i] = 1'b0; m_busy[i] = 1'b0; m_resp_e[i] = 0; m_cur_a[i] = 8'h0; m_pend_a[i] = 8'h0;
    end
    test_preload();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_collision();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
